// File: rtl/password_pkg.sv
// Shared types and 7-segment constants for the parametrised code-entry lock.
package password_pkg;

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StError   = 3'd1,
      StDone    = 3'd2,
      StLockout = 3'd3,
      StProgram = 3'd4
   } state_e;

   // Active-low segments, bit order gfedcba.
   localparam logic [6:0] Seg0 = 7'b1000000;
   localparam logic [6:0] Seg1 = 7'b1111001;
   localparam logic [6:0] Seg2 = 7'b0100100;
   localparam logic [6:0] Seg3 = 7'b0110000;
   localparam logic [6:0] Seg4 = 7'b0011001;
   localparam logic [6:0] Seg5 = 7'b0010010;
   localparam logic [6:0] Seg6 = 7'b0000010;
   localparam logic [6:0] Seg7 = 7'b1111000;
   localparam logic [6:0] Seg8 = 7'b0000000;
   localparam logic [6:0] Seg9 = 7'b0010000;
   localparam logic [6:0] SegA = 7'b0001000;
   localparam logic [6:0] SegB = 7'b0000011;
   localparam logic [6:0] SegC = 7'b1000110;
   localparam logic [6:0] SegD = 7'b0100001;
   localparam logic [6:0] SegE = 7'b0000110;
   localparam logic [6:0] SegF = 7'b0001110;

   localparam logic [6:0] SegDash  = 7'b0111111;
   localparam logic [6:0] SegBlank = 7'b1111111;
   localparam logic [6:0] SegLowR  = 7'b0101111;
   localparam logic [6:0] SegLowO  = 7'b0100011;
   localparam logic [6:0] SegCapO  = 7'b1000000;
   localparam logic [6:0] SegN     = 7'b1001000;
   localparam logic [6:0] SegL     = 7'b1000111;
   localparam logic [6:0] SegP     = 7'b0001100;
   localparam logic [6:0] SegG     = 7'b0000010;

   function automatic logic [6:0] hex_glyph(input logic [3:0] value);
      logic [6:0] g;
      case (value)
         4'h0: g = Seg0;
         4'h1: g = Seg1;
         4'h2: g = Seg2;
         4'h3: g = Seg3;
         4'h4: g = Seg4;
         4'h5: g = Seg5;
         4'h6: g = Seg6;
         4'h7: g = Seg7;
         4'h8: g = Seg8;
         4'h9: g = Seg9;
         4'hA: g = SegA;
         4'hB: g = SegB;
         4'hC: g = SegC;
         4'hD: g = SegD;
         4'hE: g = SegE;
         default: g = SegF;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/password_lock_param_if.sv
// Key inputs, status and display outputs of the code-entry lock.
interface password_lock_param_if #(
   parameter int unsigned N_SW = 10,
   parameter int unsigned FC_W = 2
);
   logic [N_SW-1:0] sw_pulse;
   logic            prog_en;
   logic            unlocked;
   logic            locked_out;
   logic [FC_W-1:0] fail_count;
   logic [6:0]      HEX0;
   logic [6:0]      HEX1;
   logic [6:0]      HEX2;
   logic [6:0]      HEX3;
   logic [6:0]      HEX4;

   modport master (
      output sw_pulse, prog_en,
      input  unlocked, locked_out, fail_count, HEX0, HEX1, HEX2, HEX3, HEX4
   );

   modport slave (
      input  sw_pulse, prog_en,
      output unlocked, locked_out, fail_count, HEX0, HEX1, HEX2, HEX3, HEX4
   );
endinterface

// File: rtl/seg_hex_glyph.sv
// 4-bit value to active-low hex glyph.
module seg_hex_glyph
   import password_pkg::*;
(
   input  logic [3:0] value_i,
   output logic [6:0] glyph_o
);

   // Pure lookup.
   always_comb begin
      glyph_o = hex_glyph(value_i);
   end

endmodule

// File: rtl/password_lock_param.sv
// Parametrised code-entry lock: reprogrammable code, inter-key timeout,
// failure counter with lockout and a shared hold/lockout/timeout down-counter.
module password_lock_param
   import password_pkg::*;
#(
   parameter int unsigned N_SW           = 10,
   parameter int unsigned CODE_LEN       = 4,
   parameter int unsigned IDX_W          = 4,
   parameter logic [31:0] CODE           = 32'h0000_1258,
   parameter int unsigned HOLD_CYCLES    = 5,
   parameter int unsigned MAX_TRIES      = 3,
   parameter int unsigned LOCKOUT_CYCLES = 20,
   parameter int unsigned TIMEOUT_CYCLES = 50
) (
   input logic                 clk,
   input logic                 rst,
   password_lock_param_if.slave bus
);

   localparam int unsigned FC_W    = $clog2(MAX_TRIES + 1);
   localparam int unsigned CODE_W  = CODE_LEN * IDX_W;
   localparam int unsigned IDXC_W  = $clog2(CODE_LEN) + 1;
   localparam int unsigned MAX_HL  = (HOLD_CYCLES > LOCKOUT_CYCLES) ? HOLD_CYCLES : LOCKOUT_CYCLES;
   localparam int unsigned MAX_CYC = (MAX_HL > TIMEOUT_CYCLES) ? MAX_HL : TIMEOUT_CYCLES;
   localparam int unsigned TMR_W   = $clog2(MAX_CYC) + 1;

   // Timer is loaded with N-1 so that a state lasts exactly N cycles.
   localparam logic [TMR_W-1:0]  HoldLoad    = TMR_W'(HOLD_CYCLES - 1);
   localparam logic [TMR_W-1:0]  LockLoad    = TMR_W'(LOCKOUT_CYCLES - 1);
   localparam logic [TMR_W-1:0]  TimeoutLoad = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [IDXC_W-1:0] IdxLast     = IDXC_W'(CODE_LEN - 1);
   localparam logic [FC_W-1:0]   FailMax     = FC_W'(MAX_TRIES);

   state_e              state_q;
   logic [IDXC_W-1:0]   idx_q;
   logic [TMR_W-1:0]    tmr_q;
   logic [FC_W-1:0]     fail_q;
   logic [CODE_W-1:0]   code_q;

   logic                key_event;
   logic                key_valid;
   logic [IDX_W-1:0]    key_idx;
   logic [IDX_W-1:0]    code_digit;
   logic [FC_W-1:0]     fail_inc;
   logic [3:0]          glyph_val;
   logic [6:0]          glyph;

   // Key decode and selection of the code digit expected next.
   always_comb begin
      key_event  = |bus.sw_pulse;
      key_valid  = $onehot(bus.sw_pulse);
      key_idx    = '0;
      code_digit = '0;
      for (int i = 0; i < int'(N_SW); i++) begin
         if (bus.sw_pulse[i]) key_idx = IDX_W'(i);
      end
      for (int k = 0; k < int'(CODE_LEN); k++) begin
         if (idx_q == IDXC_W'(k)) code_digit = code_q[k*IDX_W +: IDX_W];
      end
      fail_inc = (fail_q == FailMax) ? fail_q : fail_q + 1'b1;
   end

   // Lock FSM with digit index, shared timer, failure count and code store.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         idx_q   <= '0;
         tmr_q   <= '0;
         fail_q  <= '0;
         code_q  <= CODE_W'(CODE);
      end else begin
         unique case (state_q)
            StIdle: begin
               if (key_event) begin
                  if (key_valid && (key_idx == code_digit)) begin
                     if (idx_q == IdxLast) begin
                        state_q <= StDone;
                        idx_q   <= '0;
                        tmr_q   <= HoldLoad;
                        fail_q  <= '0;
                     end else begin
                        idx_q <= idx_q + 1'b1;
                        tmr_q <= TimeoutLoad;
                     end
                  end else begin
                     state_q <= StError;
                     idx_q   <= '0;
                     tmr_q   <= HoldLoad;
                     fail_q  <= fail_inc;
                  end
               end else if (idx_q != '0) begin
                  // Inter-key timeout only runs once entry has started.
                  if (tmr_q == '0) begin
                     state_q <= StError;
                     idx_q   <= '0;
                     tmr_q   <= HoldLoad;
                     fail_q  <= fail_inc;
                  end else begin
                     tmr_q <= tmr_q - 1'b1;
                  end
               end
            end
            StError: begin
               if (tmr_q == '0) begin
                  if (fail_q == FailMax) begin
                     state_q <= StLockout;
                     tmr_q   <= LockLoad;
                  end else begin
                     state_q <= StIdle;
                  end
               end else begin
                  tmr_q <= tmr_q - 1'b1;
               end
            end
            StLockout: begin
               if (tmr_q == '0) begin
                  state_q <= StIdle;
                  fail_q  <= '0;
               end else begin
                  tmr_q <= tmr_q - 1'b1;
               end
            end
            StDone: begin
               // Programming request wins over hold expiry.
               if (bus.prog_en) begin
                  state_q <= StProgram;
                  idx_q   <= '0;
               end else if (tmr_q == '0) begin
                  state_q <= StIdle;
               end else begin
                  tmr_q <= tmr_q - 1'b1;
               end
            end
            StProgram: begin
               if (key_valid) begin
                  for (int k = 0; k < int'(CODE_LEN); k++) begin
                     if (idx_q == IDXC_W'(k)) code_q[k*IDX_W +: IDX_W] <= key_idx;
                  end
                  if (idx_q == IdxLast) begin
                     state_q <= StIdle;
                     idx_q   <= '0;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end
            end
            default: begin
               state_q <= StIdle;
               idx_q   <= '0;
               tmr_q   <= '0;
            end
         endcase
      end
   end

   // Rightmost digit shows the failure count in lockout, otherwise the index.
   always_comb begin
      glyph_val = (state_q == StLockout) ? 4'(fail_q) : 4'(idx_q);
   end

   seg_hex_glyph u_glyph (
      .value_i (glyph_val),
      .glyph_o (glyph)
   );

   // Status and display decode from registered state only.
   always_comb begin
      bus.unlocked   = (state_q == StDone);
      bus.locked_out = (state_q == StLockout);
      bus.fail_count = fail_q;
      bus.HEX4       = SegDash;
      bus.HEX3       = SegDash;
      bus.HEX2       = SegDash;
      bus.HEX1       = SegDash;
      bus.HEX0       = glyph;
      unique case (state_q)
         StError: begin
            bus.HEX4 = SegE;
            bus.HEX3 = SegLowR;
            bus.HEX2 = SegLowR;
            bus.HEX1 = SegLowO;
            bus.HEX0 = SegLowR;
         end
         StDone: begin
            bus.HEX4 = SegBlank;
            bus.HEX3 = SegD;
            bus.HEX2 = SegCapO;
            bus.HEX1 = SegN;
            bus.HEX0 = SegE;
         end
         StLockout: begin
            bus.HEX4 = SegL;
            bus.HEX3 = SegCapO;
            bus.HEX2 = SegC;
            bus.HEX1 = SegBlank;
         end
         StProgram: begin
            bus.HEX4 = SegP;
            bus.HEX3 = SegLowR;
            bus.HEX2 = SegCapO;
            bus.HEX1 = SegG;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_password_lock_param.sv
// Bench for password_lock_param: constant vector table, directed corner
// sequences and random stimulus against a cycle-level behavioural model.
module tb_password_lock_param;

   localparam int unsigned N_SW     = 10;
   localparam int unsigned CODE_LEN = 4;
   localparam logic [31:0] CODE     = 32'h0000_1258;
   localparam int          HOLD     = 5;
   localparam int          MAXT     = 3;
   localparam int          LOCKC    = 20;
   localparam int          TMO      = 50;

   localparam int MIdle = 0, MErr = 1, MDone = 2, MLock = 3, MProg = 4;

   localparam logic [6:0] GD = 7'b0111111;
   localparam logic [6:0] GB = 7'b1111111;
   localparam logic [6:0] G0 = 7'b1000000;
   localparam logic [6:0] G1 = 7'b1111001;
   localparam logic [6:0] G2 = 7'b0100100;
   localparam logic [6:0] G3 = 7'b0110000;
   localparam logic [6:0] GE = 7'b0000110;
   localparam logic [6:0] GR = 7'b0101111;
   localparam logic [6:0] GP = 7'b0001100;
   localparam logic [6:0] GL = 7'b1000111;

   logic clk = 1'b0;
   logic rst = 1'b0;

   password_lock_param_if #(.N_SW(N_SW), .FC_W(2)) bus ();

   password_lock_param #(
      .N_SW(N_SW), .CODE_LEN(CODE_LEN), .IDX_W(4), .CODE(CODE), .HOLD_CYCLES(HOLD),
      .MAX_TRIES(MAXT), .LOCKOUT_CYCLES(LOCKC), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Behavioural model: mode, cycles spent in mode, digits accepted, idle gap.
   int m_mode, m_age, m_digits, m_idle, m_fail;
   int m_code [CODE_LEN];

   typedef struct {
      logic [9:0] p;
      logic       pr;
      logic       unl;
      logic       lk;
      logic [1:0] fc;
      logic [6:0] h4;
      logic [6:0] h0;
   } vec_t;
   vec_t vecs[$];

   function automatic logic [6:0] glyph(input int v);
      case (v)
         0: return 7'b1000000;   1: return 7'b1111001;   2: return 7'b0100100;
         3: return 7'b0110000;   4: return 7'b0011001;   5: return 7'b0010010;
         6: return 7'b0000010;   7: return 7'b1111000;   8: return 7'b0000000;
         9: return 7'b0010000;   10: return 7'b0001000;  11: return 7'b0000011;
         12: return 7'b1000110;  13: return 7'b0100001;  14: return 7'b0000110;
         default: return 7'b0001110;
      endcase
   endfunction

   function automatic logic [34:0] exp_hex();
      case (m_mode)
         MIdle: return {GD, GD, GD, GD, glyph(m_digits)};
         MErr:  return {7'b0000110, 7'b0101111, 7'b0101111, 7'b0100011, 7'b0101111};
         MDone: return {7'b1111111, 7'b0100001, 7'b1000000, 7'b1001000, 7'b0000110};
         MLock: return {7'b1000111, 7'b1000000, 7'b1000110, 7'b1111111, glyph(m_fail)};
         default: return {7'b0001100, 7'b0101111, 7'b1000000, 7'b0000010, glyph(m_digits)};
      endcase
   endfunction

   function automatic logic [9:0] bit_of(input int d);
      logic [9:0] p;
      p = '0;
      p[d] = 1'b1;
      return p;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, "_status"}, {61'd0, bus.unlocked, bus.locked_out, bus.fail_count},
            {61'd0, m_mode == MDone, m_mode == MLock, 2'(m_fail)});
      check({tag, "_hex"}, {29'd0, bus.HEX4, bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0},
            {29'd0, exp_hex()});
   endtask

   task automatic model_reset();
      m_mode = MIdle; m_age = 0; m_digits = 0; m_idle = 0; m_fail = 0;
      for (int k = 0; k < int'(CODE_LEN); k++) m_code[k] = int'((CODE >> (4 * k)) & 32'hF);
   endtask

   task automatic model_error();
      m_mode = MErr; m_age = 0; m_digits = 0; m_idle = 0;
      m_fail = (m_fail < MAXT) ? m_fail + 1 : MAXT;
   endtask

   task automatic model_step(input logic [9:0] p, input logic pr);
      int ones;
      int dig;
      ones = $countones(p);
      dig = 0;
      for (int i = 0; i < int'(N_SW); i++) if (p[i]) dig = i;
      case (m_mode)
         MIdle: begin
            if (p != 0) begin
               m_idle = 0;
               if (ones == 1 && dig == m_code[m_digits]) begin
                  m_digits++;
                  if (m_digits == int'(CODE_LEN)) begin
                     m_digits = 0; m_fail = 0; m_mode = MDone; m_age = 0;
                  end
               end else model_error();
            end else if (m_digits > 0) begin
               m_idle++;
               if (m_idle == TMO) model_error();
            end
         end
         MErr: begin
            m_age++;
            if (m_age == HOLD) begin
               m_mode = (m_fail == MAXT) ? MLock : MIdle;
               m_age = 0;
            end
         end
         MLock: begin
            m_age++;
            if (m_age == LOCKC) begin m_mode = MIdle; m_fail = 0; m_age = 0; end
         end
         MDone: begin
            if (pr) begin
               m_mode = MProg; m_digits = 0;
            end else begin
               m_age++;
               if (m_age == HOLD) begin m_mode = MIdle; m_age = 0; end
            end
         end
         default: begin
            if (ones == 1) begin
               m_code[m_digits] = dig;
               m_digits++;
               if (m_digits == int'(CODE_LEN)) begin m_digits = 0; m_mode = MIdle; end
            end
         end
      endcase
   endtask

   // One clock with the given inputs held for that cycle, then model check.
   task automatic cyc(input logic [9:0] p, input logic pr);
      bus.sw_pulse = p;
      bus.prog_en  = pr;
      @(posedge clk);
      #1;
      bus.sw_pulse = '0;
      bus.prog_en  = 1'b0;
      model_step(p, pr);
      check_model("model");
   endtask

   task automatic do_reset();
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      check_model("reset");
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc('0, 1'b0);
   endtask

   task automatic enter(input int a, input int b, input int c, input int d);
      cyc(bit_of(a), 1'b0); cyc(bit_of(b), 1'b0); cyc(bit_of(c), 1'b0); cyc(bit_of(d), 1'b0);
   endtask

   task automatic add(input logic [9:0] p, input logic unl, input logic lk, input logic [1:0] fc,
                      input logic [6:0] h4, input logic [6:0] h0);
      vec_t v;
      v.p = p; v.pr = 1'b0; v.unl = unl; v.lk = lk; v.fc = fc; v.h4 = h4; v.h0 = h0;
      vecs.push_back(v);
   endtask

   initial begin
      logic [9:0] p;
      int r;
      bus.sw_pulse = '0;
      bus.prog_en  = 1'b0;

      // Correct code with 3-cycle gaps, then a hold of exactly 5 cycles.
      add(bit_of(8), 0, 0, 0, GD, G1);
      for (int i = 0; i < 3; i++) add('0, 0, 0, 0, GD, G1);
      add(bit_of(5), 0, 0, 0, GD, G2);
      for (int i = 0; i < 3; i++) add('0, 0, 0, 0, GD, G2);
      add(bit_of(2), 0, 0, 0, GD, G3);
      for (int i = 0; i < 3; i++) add('0, 0, 0, 0, GD, G3);
      for (int i = 0; i < 5; i++) add(i == 0 ? bit_of(1) : 10'd0, 1, 0, 0, GB, GE);
      add('0, 0, 0, 0, GD, G0);
      // Wrong third digit.
      add(bit_of(8), 0, 0, 0, GD, G1);
      add(bit_of(5), 0, 0, 0, GD, G2);
      for (int i = 0; i < 5; i++) add(i == 0 ? bit_of(3) : 10'd0, 0, 0, 1, GE, GR);
      add('0, 0, 0, 1, GD, G0);
      // Multi-hot first key.
      for (int i = 0; i < 5; i++) add(i == 0 ? 10'h120 : 10'd0, 0, 0, 2, GE, GR);
      add('0, 0, 0, 2, GD, G0);
      // Third consecutive failure leads into lockout.
      for (int i = 0; i < 5; i++) add(i == 0 ? bit_of(1) : 10'd0, 0, 0, 3, GE, GR);
      add('0, 0, 1, 3, GL, G3);

      do_reset();
      foreach (vecs[i]) begin
         cyc(vecs[i].p, vecs[i].pr);
         check($sformatf("vec%0d", i), {45'd0, bus.unlocked, bus.locked_out, bus.fail_count,
               bus.HEX4, bus.HEX0},
               {45'd0, vecs[i].unl, vecs[i].lk, vecs[i].fc, vecs[i].h4, vecs[i].h0});
      end

      // Lockout lasts 20 cycles in total and ignores a correct code.
      enter(8, 5, 2, 1);
      for (int i = 0; i < LOCKC - 5; i++) begin
         cyc('0, 1'b0);
         check("lock_hold", {62'd0, bus.locked_out, bus.unlocked}, 64'd2);
      end
      cyc('0, 1'b0);
      check("lock_exit", {55'd0, bus.locked_out, bus.fail_count, bus.HEX0}, {55'd0, 1'b0, 2'd0, G0});

      // Gap of 49 idle cycles is tolerated, 50 is a timeout.
      do_reset();
      cyc(bit_of(8), 1'b0);
      idle(TMO - 1);
      cyc(bit_of(5), 1'b0);
      check("tmo_49_accept", {57'd0, bus.HEX0}, {57'd0, G2});
      idle(TMO - 1);
      check("tmo_49_still_idle", {57'd0, bus.HEX4}, {57'd0, GD});
      cyc('0, 1'b0);
      check("tmo_50_error", {55'd0, bus.fail_count, bus.HEX4}, {55'd0, 2'd1, GE});

      // Reprogramming through DONE.
      do_reset();
      enter(8, 5, 2, 1);
      cyc('0, 1'b1);
      check("prog_enter", {50'd0, bus.HEX4, bus.HEX0}, {50'd0, GP, G0});
      cyc(bit_of(0), 1'b0);
      check("prog_d1", {57'd0, bus.HEX0}, {57'd0, G1});
      cyc(bit_of(9), 1'b0);
      cyc(bit_of(9), 1'b0);
      cyc(10'h018, 1'b0);
      check("prog_multihot_ignored", {50'd0, bus.HEX4, bus.HEX0}, {50'd0, GP, G3});
      cyc(bit_of(4), 1'b0);
      check("prog_exit", {50'd0, bus.HEX4, bus.HEX0}, {50'd0, GD, G0});
      cyc(bit_of(8), 1'b0);
      check("old_code_rejected", {57'd0, bus.HEX4}, {57'd0, GE});
      idle(HOLD);
      enter(0, 9, 9, 4);
      check("new_code_unlocks", {63'd0, bus.unlocked}, 64'd1);

      // Reset in the middle of programming restores the reset code.
      cyc('0, 1'b1);
      cyc(bit_of(3), 1'b0);
      cyc(bit_of(3), 1'b0);
      do_reset();
      check("reset_mid_prog", {50'd0, bus.HEX4, bus.HEX0}, {50'd0, GD, G0});
      enter(8, 5, 2, 1);
      check("reset_code_restored", {63'd0, bus.unlocked}, 64'd1);

      // Random traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         r = int'($urandom_range(0, 99));
         p = '0;
         if (r < 55) begin
            p = '0;
         end else if (r < 75) begin
            if (m_mode == MIdle) p = bit_of(m_code[m_digits]);
            else p = bit_of(int'($urandom_range(0, N_SW - 1)));
         end else if (r < 88) begin
            p = bit_of(int'($urandom_range(0, N_SW - 1)));
         end else if (r < 94) begin
            p = 10'($urandom) | bit_of(0) | bit_of(int'($urandom_range(1, N_SW - 1)));
         end else if (r < 98) begin
            p = '0;
         end else begin
            idle(int'($urandom_range(TMO - 3, TMO + 3)));
         end
         cyc(p, ($urandom_range(0, 9) == 0));
         if ($urandom_range(0, 499) == 0) do_reset();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
